// File: rtl/snake_pkg.sv
// Shared configuration and types for the snake segment buffer.
package snake_pkg;
    localparam int COORD_W  = 10;
    localparam int SEG_SIZE = 20;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int IDX_W    = $clog2(MAX_LEN);
    localparam int START_X  = 20;
    localparam int START_Y  = 20;

    typedef enum logic [1:0] {IDLE, SCAN, HIT} state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;
endpackage

// File: rtl/snake_body_seg_hit_cmp.sv
// Combinational rectangle test of one segment against the raster position.
module seg_hit_cmp
    import snake_pkg::*;
(
    input  seg_t               seg,
    input  logic [COORD_W-1:0] x_count,
    input  logic [COORD_W-1:0] y_count,
    output logic               hit
);
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    // One extra bit so segments near the coordinate limit do not wrap.
    assign x_end = {1'b0, seg.x} + (COORD_W+1)'(SEG_SIZE);
    assign y_end = {1'b0, seg.y} + (COORD_W+1)'(SEG_SIZE);

    assign hit = (x_count > seg.x) && ({1'b0, x_count} < x_end) &&
                 (y_count > seg.y) && ({1'b0, y_count} < y_end);
endmodule

// File: rtl/snake_body.sv
// Snake segment shift buffer with per-step self-collision scan and registered body pixel.
module snake_body
    import snake_pkg::*;
(
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               step,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic               grow,
    input  logic               clear,
    input  logic [COORD_W-1:0] x_count,
    input  logic [COORD_W-1:0] y_count,
    output logic               body_pix,
    output logic [LEN_W-1:0]   length,
    output logic               self_hit,
    output logic               busy
);
    seg_t             seg_q [MAX_LEN];
    seg_t             seg_d [MAX_LEN];
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             grow_pend_q, grow_pend_d;
    logic             body_pix_q, body_pix_d;
    logic [MAX_LEN-1:1] hit;
    logic [LEN_W-1:0] lim;
    logic             accept;

    state_e           state_q;
    logic [LEN_W-1:0] idx_q;
    logic             self_hit_q;
    logic             busy_q;

    for (genvar g = 1; g < MAX_LEN; g++) begin : g_cmp
        seg_hit_cmp u_cmp (
            .seg     (seg_q[g]),
            .x_count (x_count),
            .y_count (y_count),
            .hit     (hit[g])
        );
    end

    assign accept = step && (state_q == IDLE) && !clear;
    assign lim    = (fill_q < length_q) ? fill_q : length_q;

    always_comb begin
        seg_d       = seg_q;
        fill_d      = fill_q;
        length_d    = length_q;
        grow_pend_d = grow_pend_q | grow;
        body_pix_d  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (hit[i] && (LEN_W'(i) < length_q) && (LEN_W'(i) < fill_q))
                body_pix_d = 1'b1;
        end
        if (clear) begin
            fill_d      = '0;
            length_d    = LEN_W'(INIT_LEN);
            grow_pend_d = 1'b0;
            body_pix_d  = 1'b0;
        end else if (accept) begin
            for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
            seg_d[0] = '{x: head_x, y: head_y};
            if (fill_q != LEN_W'(MAX_LEN)) fill_d = fill_q + 1'b1;
            // Growth requested at full length is dropped, not deferred.
            if ((grow_pend_q || grow) && (length_q < LEN_W'(MAX_LEN)))
                length_d = length_q + 1'b1;
            grow_pend_d = 1'b0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= '0;
            fill_q      <= '0;
            length_q    <= LEN_W'(INIT_LEN);
            grow_pend_q <= 1'b0;
            body_pix_q  <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            fill_q      <= fill_d;
            length_q    <= length_d;
            grow_pend_q <= grow_pend_d;
            body_pix_q  <= body_pix_d;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset || clear) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            self_hit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    self_hit_q <= 1'b0;
                    if (step) begin
                        state_q <= SCAN;
                        idx_q   <= LEN_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx_q >= lim) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (seg_q[idx_q[IDX_W-1:0]] == seg_q[0]) begin
                        state_q    <= HIT;
                        self_hit_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                HIT: begin
                    state_q    <= IDLE;
                    self_hit_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    self_hit_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign body_pix = body_pix_q;
    assign length   = length_q;
    assign self_hit = self_hit_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_snake_body.sv
// Randomized and directed bench for snake_body against a list-based trail model.
module tb_snake_body;
    localparam int ML = 16;
    localparam int IL = 3;
    localparam int SS = 20;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b0;
    logic       step = 1'b0;
    logic       grow = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] head_x = '0;
    logic [9:0] head_y = '0;
    logic [9:0] x_count = '0;
    logic [9:0] y_count = '0;
    logic       body_pix;
    logic       self_hit;
    logic       busy;
    logic [4:0] length;

    int checks = 0;
    int errors = 0;

    // Trail model: index 0 is the newest head, older positions follow.
    int mx[ML];
    int my[ML];
    int m_fill;
    int m_len;
    bit m_pend;

    always #20 vga_clk = ~vga_clk;

    snake_body dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .step     (step),
        .head_x   (head_x),
        .head_y   (head_y),
        .grow     (grow),
        .clear    (clear),
        .x_count  (x_count),
        .y_count  (y_count),
        .body_pix (body_pix),
        .length   (length),
        .self_hit (self_hit),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic int m_lim();
        return (m_fill < m_len) ? m_fill : m_len;
    endfunction

    function automatic bit m_body(int x, int y);
        for (int i = 1; i < m_lim(); i++)
            if (x > mx[i] && x < mx[i] + SS && y > my[i] && y < my[i] + SS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_hit_idx();
        for (int i = 1; i < m_lim(); i++)
            if (mx[i] == mx[0] && my[i] == my[0]) return i;
        return 0;
    endfunction

    task automatic m_reset(bit wipe);
        m_fill = 0;
        m_len  = IL;
        m_pend = 1'b0;
        if (wipe) for (int i = 0; i < ML; i++) begin mx[i] = 0; my[i] = 0; end
    endtask

    task automatic m_step(int x, int y, bit g);
        for (int i = ML - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
        mx[0] = x;
        my[0] = y;
        if ((m_pend || g) && m_len < ML) m_len++;
        m_pend = 1'b0;
        if (m_fill < ML) m_fill++;
    endtask

    task automatic check_pix(int x, int y, string nm);
        bit exp;
        exp = m_body(x, y);
        x_count = 10'(x);
        y_count = 10'(y);
        tick();
        checks++;
        if (body_pix !== exp)
            $display("FAIL %s body_pix at (%0d,%0d): got %b want %b", nm, x, y, body_pix, exp);
        if (body_pix !== exp) errors++;
    endtask

    task automatic do_step(int x, int y, bit g, string nm);
        int exp_k, exp_busy, bc, sc, sc_at;
        head_x = 10'(x);
        head_y = 10'(y);
        grow   = g;
        step   = 1'b1;
        tick();
        step = 1'b0;
        grow = 1'b0;
        m_step(x, y, g);
        exp_k    = m_hit_idx();
        exp_busy = (exp_k != 0) ? exp_k + 1 : m_lim();
        bc = 0; sc = 0; sc_at = -1;
        while (busy === 1'b1 && bc < 3 * ML) begin
            if (self_hit === 1'b1) begin sc++; sc_at = bc; end
            bc++;
            tick();
        end
        checks++;
        if (bc != exp_busy) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", nm, bc, exp_busy);
        end
        checks++;
        if (sc != ((exp_k != 0) ? 1 : 0) || (exp_k != 0 && sc_at != exp_k)) begin
            errors++;
            $display("FAIL %s self_hit: got %0d pulses at %0d want hit idx %0d", nm, sc, sc_at, exp_k);
        end
        checks++;
        if (length !== 5'(m_len)) begin
            errors++;
            $display("FAIL %s length: got %0d want %0d", nm, length, m_len);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_reset(1'b1);
        checks++;
        if (length !== 5'(IL) || busy !== 1'b0 || self_hit !== 1'b0 || body_pix !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: len=%0d busy=%b hit=%b pix=%b want 3/0/0/0",
                     length, busy, self_hit, body_pix);
        end
        check_pix(5, 5, "reset_pix");
    endtask

    task automatic test_basic();
        do_step(20, 20, 1'b0, "basic0");
        do_step(25, 20, 1'b0, "basic1");
        do_step(30, 20, 1'b0, "basic2");
        check_pix(26, 25, "inside_seg1");
        check_pix(20, 25, "strict_edge");
        check_pix(21, 25, "oldest_seg");
        check_pix(46, 25, "head_only");
        checks++;
        if (m_body(26, 25) !== 1'b1 || m_body(20, 25) !== 1'b0 || m_body(46, 25) !== 1'b0) begin
            errors++;
            $display("FAIL basic_model_sanity: model disagrees with hand values");
        end
    endtask

    task automatic test_grow();
        grow = 1'b1;
        tick();
        grow = 1'b0;
        m_pend = 1'b1;
        do_step(35, 20, 1'b0, "grow_pend");
        do_step(40, 20, 1'b1, "grow_coinc");
        for (int i = 0; i < 14; i++) do_step(45 + 5 * i, 20, 1'b1, "grow_sat");
        checks++;
        if (length !== 5'(ML)) begin
            errors++;
            $display("FAIL grow_saturate length: got %0d want %0d", length, ML);
        end
    endtask

    task automatic test_self_hit();
        do_step(mx[2], my[2], 1'b0, "self_hit_seg3");
    endtask

    task automatic test_drop();
        int bc;
        head_x = 10'd700; head_y = 10'd300; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_busy: got %b want 1", busy);
        end
        head_x = 10'd100; head_y = 10'd400; step = 1'b1;
        tick();
        step = 1'b0;
        m_step(700, 300, 1'b0);
        bc = 0;
        while (busy === 1'b1 && bc < 3 * ML) begin bc++; tick(); end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_timeout: busy still %b after %0d cycles", busy, bc);
        end
        do_step(300, 100, 1'b0, "after_drop");
        check_pix(710, 310, "first_head_kept");
        check_pix(110, 410, "dropped_head");
    endtask

    task automatic test_random();
        int x, y, j;
        for (int n = 0; n < 40; n++) begin
            if (m_fill > 0 && $urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, m_fill - 1);
                x = mx[j]; y = my[j];
            end else begin
                x = $urandom_range(0, 600); y = $urandom_range(0, 440);
            end
            if ($urandom_range(0, 4) == 0) begin
                grow = 1'b1; tick(); grow = 1'b0; m_pend = 1'b1;
            end
            do_step(x, y, 1'(($urandom_range(0, 3) == 0)), "rand_step");
            j = $urandom_range(1, ML - 1);
            check_pix(mx[j] + $urandom_range(0, SS), my[j] + $urandom_range(0, SS), "rand_seg_pix");
            check_pix($urandom_range(0, 639), $urandom_range(0, 479), "rand_pix");
        end
    endtask

    task automatic test_clear();
        int seen;
        head_x = 10'd500; head_y = 10'd200; step = 1'b1;
        tick();
        step = 1'b0;
        grow = 1'b1;
        tick();
        grow = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_step(500, 200, 1'b0);
        m_reset(1'b0);
        checks++;
        if (busy !== 1'b0 || self_hit !== 1'b0 || length !== 5'(IL)) begin
            errors++;
            $display("FAIL clear_outputs: busy=%b hit=%b len=%0d want 0/0/3", busy, self_hit, length);
        end
        seen = 0;
        for (int y = 0; y < 480; y += 7)
            for (int x = 0; x < 640; x += 7) begin
                x_count = 10'(x); y_count = 10'(y);
                tick();
                if (body_pix !== 1'b0) seen++;
            end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL clear_frame body_pix: got %0d lit samples want 0", seen);
        end
        do_step(200, 200, 1'b0, "post_clear_step");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) do_step(60 + 30 * i, 150, 1'b1, "build_len10");
        checks++;
        if (length !== 5'd10) begin
            errors++;
            $display("FAIL build_len10 length: got %0d want 10", length);
        end
        check_pix(mx[1] + 5, my[1] + 5, "pre_reset_pix");
        head_x = 10'd400; head_y = 10'd400; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (body_pix !== 1'b0 || self_hit !== 1'b0 || busy !== 1'b0 || length !== 5'(IL)) begin
            errors++;
            $display("FAIL reset_mid: pix=%b hit=%b busy=%b len=%0d want 0/0/0/3",
                     body_pix, self_hit, busy, length);
        end
        reset = 1'b1;
        m_reset(1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grow();
        test_self_hit();
        test_drop();
        test_random();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
